router_dest_fifo: RTL
=====================

Name: router_dest_fifo

Overview:
- Parametrised per-destination output buffer for the 1x3 router. One instance per output port.
- Accepts bytes from the router core's write side and presents them to the destination agent over the read_enb / data_out / vld_out handshake.
- Generalises the fixed 8-bit, 16-deep port: configurable width, depth and timeout.
- Adds packet-boundary tracking and a read-timeout soft reset that flushes an abandoned packet.

Parameters:
- DATA_W, 8, data byte width; header bits [DATA_W-1:2] = payload length, bits [1:0] = address.
- DEPTH, 16, entries; power of two, >= 4.
- TIMEOUT, 30, consecutive stalled cycles before soft reset; >= 2.

Ports:
- clock  in  1  single system clock, all logic on posedge.
- reset  in  1  synchronous reset, active-high.
- write_enb  in  1  write request from router core.
- lfd_state  in  1  marks data_in as packet header (first byte).
- data_in  in  DATA_W  write data.
- read_enb  in  1  read request from destination.
- data_out  out  DATA_W  registered read data.
- vld_out  out  1  FIFO not empty.
- full  out  1  FIFO holds DEPTH entries.
- soft_reset  out  1  one-cycle pulse on timeout flush.
- busy_pkt  out  1  packet partially read (header read, parity not yet read).

Behaviour:
- Reset (reset=1 at posedge): pointers, count, timeout counter and packet counter = 0; data_out=0, vld_out=0, full=0, soft_reset=0, busy_pkt=0.
- Storage: DEPTH x (DATA_W+1); the extra bit stores lfd_state alongside data.
- Write: when write_enb=1 and full=0, store {lfd_state, data_in}, advance wr_ptr. Writes while full are dropped, even if a read occurs in the same cycle.
- Read: when read_enb=1 and vld_out=1, data_out takes the head entry at that posedge (1-cycle latency) and rd_ptr advances. When there is no read, data_out holds its value.
- Simultaneous read and write when not full and not empty: both proceed; count unchanged.
- Write to an empty FIFO: vld_out rises the next cycle. A read_enb in that same cycle is ignored.
- Pointers wrap modulo DEPTH. full/vld_out are derived from a count of width $clog2(DEPTH)+1, registered together with count.
- Packet counter (width DATA_W-2+1):
  - Reading an entry with lfd bit=1 loads header[DATA_W-1:2]+1 (payload plus parity byte) and sets busy_pkt.
  - Each later read decrements the counter; reaching 0 clears busy_pkt.
  - A header read while busy_pkt=1 reloads the counter (malformed-packet recovery).
- Timeout:
  - The counter increments each cycle with vld_out=1 and read_enb=0.
  - It clears on read_enb=1 or vld_out=0.
  - When it reaches TIMEOUT-1 and the stall persists: next cycle soft_reset=1 for one cycle; FIFO, pointers, packet counter and busy_pkt clear; data_out=0.
- Soft reset vs write in the same cycle: soft reset wins and the write is dropped.
- Hard reset mid-operation: everything clears identically to power-on; no partial state survives.

Optional Feature:
- Macro: ROUTER_DEST_PARITY_CHK_EN.
- Defined:
  - Running XOR over header and payload bytes as they are read.
  - On reading the final (parity) byte, compare it against the running XOR. A mismatch drives output parity_err=1 for one cycle, coincident with data_out showing the parity byte.
  - The running XOR clears on header read, reset and soft_reset.
- Undefined: no parity_err port and no XOR logic.

Decomposition:
- Shared package router_dest_pkg holds:
  - typedef entry_t {logic lfd; logic [DATA_W-1:0] data;}
  - function hdr_len() extracting the payload length
  - localparams for the address field width (2) and default TIMEOUT.
- One natural sub-module: router_dest_timeout (stall counter, soft_reset pulse generation), parametrised by TIMEOUT.

Test Plan:
- Reset then write header 8'h0D (len 3, addr 1) plus 3 payload bytes plus parity, then read 5 times:
  - vld_out rises 1 cycle after the first write.
  - data_out = 0D, payload bytes, parity in order, each 1 cycle after its read_enb.
  - busy_pkt high from the header read through the parity read.
  - vld_out=0 after the 5th read.
- Write 16 bytes with DEPTH=16 → full=1. A 17th write with a concurrent read → write dropped, count=15. Subsequent read data matches the first 16 only.
- Fill 4 bytes, hold read_enb=0 for 30 cycles → soft_reset pulse on cycle 31. Then vld_out=0, data_out=0, busy_pkt=0, and a write in the pulse cycle is absent.
- Read stall of 29 cycles, one read_enb, then 29 more stall cycles → no soft_reset.
- Assert reset mid-packet (after 2 of 5 reads) → next cycle all outputs 0; a fresh packet is then read correctly.
- With ROUTER_DEST_PARITY_CHK_EN: packet 0D,11,22,33 with parity 0x0D^0x11^0x22^0x33=0x0D → parity_err=0. The same packet with parity 0x0C → parity_err=1 for one cycle.

Source files
------------

// File: rtl/router_dest_pkg.sv
// Shared types and constants for the per-destination router output buffer.
// The parity checker in router_dest_fifo is enabled by defining ROUTER_DEST_PARITY_CHK_EN.
package router_dest_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int ADDR_W      = 2;
   localparam int DEF_TIMEOUT = 30;

   typedef struct packed {
      logic                  lfd;
      logic [DEF_DATA_W-1:0] data;
   } entry_t;

   // Header layout: payload length above the destination address field.
   function automatic logic [DEF_DATA_W-ADDR_W-1:0] hdr_len(input entry_t e);
      return e.data[DEF_DATA_W-1:ADDR_W];
   endfunction

endpackage

// File: rtl/router_dest_timeout.sv
// Read-stall watchdog: counts cycles with data waiting and no read, and
// requests a flush (followed by a one-cycle soft_reset pulse) after TIMEOUT of them.
module router_dest_timeout
   import router_dest_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic vld_out,
   input  logic read_enb,
   output logic flush,
   output logic soft_reset
);

   localparam int TO_W = $clog2(TIMEOUT);

   logic [TO_W-1:0] stall_cnt;
   logic            stalled;

   assign stalled = vld_out & ~read_enb;
   assign flush   = stalled & (stall_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt  <= '0;
         soft_reset <= 1'b0;
      end else begin
         soft_reset <= flush;
         if (flush || !stalled) begin
            stall_cnt <= '0;
         end else begin
            stall_cnt <= stall_cnt + TO_W'(1);
         end
      end
   end

endmodule

// File: rtl/router_dest_fifo.sv
// Per-destination output FIFO with packet-boundary tracking and read-timeout flush.
// Optional parity check of each packet is built when ROUTER_DEST_PARITY_CHK_EN is defined.
module router_dest_fifo
   import router_dest_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              write_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_enb,
   output logic [DATA_W-1:0] data_out,
   output logic              vld_out,
   output logic              full,
   output logic              soft_reset,
   output logic              busy_pkt
`ifdef ROUTER_DEST_PARITY_CHK_EN
   ,
   output logic              parity_err
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LEN_W = DATA_W - ADDR_W;
   localparam int PKT_W = LEN_W + 1;

   typedef struct packed {
      logic              lfd;
      logic [DATA_W-1:0] data;
   } slot_t;

   slot_t            mem [DEPTH];
   slot_t            head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [PKT_W-1:0] pkt_cnt;
   logic             pkt_last;
   logic             do_write;
   logic             do_read;
   logic             flush;

   router_dest_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock      (clock),
      .reset      (reset),
      .vld_out    (vld_out),
      .read_enb   (read_enb),
      .flush      (flush),
      .soft_reset (soft_reset)
   );

   // A write is lost while full (even alongside a read), and during the flush
   // edge and the soft_reset pulse that follows it.
   assign do_write   = write_enb & ~full & ~flush & ~soft_reset;
   assign do_read    = read_enb & vld_out;
   assign head       = mem[rd_ptr];
   assign pkt_last   = (pkt_cnt == PKT_W'(1));
   assign count_next = count + CNT_W'(do_write) - CNT_W'(do_read);

   always_ff @(posedge clock) begin
      if (do_write) begin
         mem[wr_ptr] <= '{lfd: lfd_state, data: data_in};
      end
   end

   // Pointer, occupancy, read data and packet tracking state.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         vld_out  <= 1'b0;
         data_out <= '0;
         pkt_cnt  <= '0;
         busy_pkt <= 1'b0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_read) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            data_out <= head.data;
            if (head.lfd) begin
               pkt_cnt  <= {1'b0, head.data[DATA_W-1:ADDR_W]} + PKT_W'(1);
               busy_pkt <= 1'b1;
            end else if (busy_pkt) begin
               pkt_cnt <= pkt_cnt - PKT_W'(1);
               if (pkt_last) begin
                  busy_pkt <= 1'b0;
               end
            end
         end
         count   <= count_next;
         full    <= (count_next == CNT_W'(DEPTH));
         vld_out <= (count_next != '0);
      end
   end

`ifdef ROUTER_DEST_PARITY_CHK_EN
   logic [DATA_W-1:0] parity_acc;

   // Running XOR of header and payload; the final byte of a packet is its parity.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         parity_acc <= '0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         if (do_read) begin
            if (head.lfd) begin
               parity_acc <= head.data;
            end else if (busy_pkt) begin
               if (pkt_last) begin
                  parity_err <= (head.data != parity_acc);
                  parity_acc <= '0;
               end else begin
                  parity_acc <= parity_acc ^ head.data;
               end
            end
         end
      end
   end
`endif

endmodule
